cam_capture: RTL and testbench

Receiving end of the OV7670-style parallel camera interface (CAM_PCLK / CAM_VSYNC / CAM_HREF / CAM_px_data). It samples RGB565 byte pairs and packs each pair into one reduced-depth pixel. It writes each pixel into the frame buffer with a linear address, and flags complete or truncated frames. It sits between the camera pins and the dual-port frame buffer read by the VGA driver inside test_cam.

---
 rtl/cam_pkg.sv | 15 +
 rtl/cam_capture_if.sv | 21 ++
 rtl/cam_px_pack.sv | 17 +
 rtl/cam_capture.sv | 88 ++++++++
 tb/tb_cam_capture.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: frame geometry, pixel width and FSM encoding shared by the capture path (PX_W set by CAM_CAPTURE_RGB444_EN)
package cam_pkg;
  localparam int H_PIXELS = 160;
  localparam int V_LINES = 120;
  localparam int FRAME_PIXELS = H_PIXELS * V_LINES;
  localparam int ADDR_W = 15;
  localparam int COL_W = $clog2(H_PIXELS + 1);
  localparam int LINE_W = $clog2(V_LINES + 2);
`ifdef CAM_CAPTURE_RGB444_EN
  localparam int PX_W = 12;
`else
  localparam int PX_W = 8;
`endif
  typedef enum logic [1:0] {IDLE, WAIT_HREF, BYTE_HI, BYTE_LO} state_e;
endpackage

// File: rtl/cam_capture_if.sv
// cam_capture_if: camera pins plus frame-buffer write port; master drives the camera side, slave is the capture block
interface cam_capture_if;
  import cam_pkg::*;
  logic capture_en;
  logic CAM_VSYNC;
  logic CAM_HREF;
  logic [7:0] CAM_px_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [PX_W-1:0] mem_data;
  logic mem_we;
  logic frame_done;
  logic frame_err;
  modport master (
    output capture_en, CAM_VSYNC, CAM_HREF, CAM_px_data,
    input  mem_addr, mem_data, mem_we, frame_done, frame_err
  );
  modport slave (
    input  capture_en, CAM_VSYNC, CAM_HREF, CAM_px_data,
    output mem_addr, mem_data, mem_we, frame_done, frame_err
  );
endinterface

// File: rtl/cam_px_pack.sv
// cam_px_pack: combinational RGB565 byte pair to RGB332, or RGB444 when CAM_CAPTURE_RGB444_EN is defined
module cam_px_pack
  import cam_pkg::*;
(
  input  logic [7:0]      hi_i,
  input  logic [7:0]      lo_i,
  output logic [PX_W-1:0] px_o
);
  logic unused_bits;
`ifdef CAM_CAPTURE_RGB444_EN
  assign px_o = {hi_i[7:4], hi_i[2:0], lo_i[7], lo_i[4:1]};
  assign unused_bits = ^{hi_i[3], lo_i[6:5], lo_i[0]};
`else
  assign px_o = {hi_i[7:5], hi_i[2:0], lo_i[4:3]};
  assign unused_bits = ^{hi_i[4:3], lo_i[7:5], lo_i[2:0]};
`endif
endmodule

// File: rtl/cam_capture.sv
// cam_capture: samples OV7670 byte pairs, packs them and writes a linear frame buffer, flagging full/truncated frames
// Pixel format selected by CAM_CAPTURE_RGB444_EN (see cam_px_pack).
module cam_capture
  import cam_pkg::*;
(
  input logic clk,
  input logic rst,
  cam_capture_if.slave bus
);
  state_e state_q, state_d;
  logic vs_q, vs_rise, vs_fall, in_line, line_end, start, live, take_hi, take_lo, col_ok, wr;
  logic [7:0] hi_q, hi_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d, line_tot;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [PX_W-1:0] px, data_q, data_d;
  logic we_q, we_d, done_q, done_d, err_q, err_d;

  cam_px_pack u_pack (.hi_i(hi_q), .lo_i(bus.CAM_px_data), .px_o(px));

  assign vs_rise  = bus.CAM_VSYNC & ~vs_q;
  assign vs_fall  = ~bus.CAM_VSYNC & vs_q;
  assign in_line  = state_q == BYTE_HI || state_q == BYTE_LO;
  assign line_end = in_line & ~bus.CAM_HREF;
  assign start    = state_q == IDLE && vs_fall && bus.capture_en;
  assign live     = state_q != IDLE && !vs_rise;
  assign take_hi  = live && bus.CAM_HREF && state_q != BYTE_LO;
  assign take_lo  = live && bus.CAM_HREF && state_q == BYTE_LO;
  assign col_ok   = col_q < COL_W'(H_PIXELS);
  assign wr       = take_lo && col_ok && line_q < LINE_W'(V_LINES);
  // a line whose HREF falls on the VSYNC-rise edge still counts toward the frame
  assign line_tot = line_q + LINE_W'(line_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vs_q    <= 1'b0;
      hi_q    <= '0;
      col_q   <= '0;
      line_q  <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= bus.CAM_VSYNC;
      hi_q    <= hi_d;
      col_q   <= col_d;
      line_q  <= line_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q == IDLE ? (start ? WAIT_HREF : IDLE) :
              vs_rise ? IDLE :
              bus.CAM_HREF ? (state_q == BYTE_LO ? BYTE_HI : BYTE_LO) :
              in_line ? WAIT_HREF : state_q;
  end

  // line counter saturates just past V_LINES so overlong frames still report an error
  always_comb begin
    hi_d   = take_hi ? bus.CAM_px_data : hi_q;
    col_d  = start || (live && line_end) ? '0 : col_q + COL_W'(take_lo && col_ok);
    line_d = start ? '0 : line_q + LINE_W'(live && line_end && line_q <= LINE_W'(V_LINES));
    base_d = start ? '0 :
             live && line_end && line_q < LINE_W'(V_LINES) ? base_q + ADDR_W'(H_PIXELS) : base_q;
    addr_d = wr ? base_q + ADDR_W'(col_q) : addr_q;
    data_d = wr ? px : data_q;
    we_d   = wr;
    done_d = state_q != IDLE && vs_rise && line_tot == LINE_W'(V_LINES);
    err_d  = state_q != IDLE && vs_rise && line_tot != LINE_W'(V_LINES);
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_data   = data_q;
  assign bus.mem_we     = we_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: random-byte camera frames checked against a frame-geometry write model
module tb_cam_capture;
  import cam_pkg::*;
  typedef struct {int addr; int data; int cyc;} wr_t;
`ifdef CAM_CAPTURE_RGB444_EN
  localparam logic [31:0] PX_EXP = 32'hF0F;
`else
  localparam logic [31:0] PX_EXP = 32'hE3;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  cam_capture_if bus();
  cam_capture dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0, cyc = 0;
  int line_n = 0, byte_n = 0, exp_wr = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0;
  bit cap = 1'b0, prev_we = 1'b0;
  logic [7:0] hi_b = '0;
  wr_t exp_q[$];

  function automatic int pack(input logic [7:0] hi, input logic [7:0] lo);
    int h = int'(hi);
    int l = int'(lo);
`ifdef CAM_CAPTURE_RGB444_EN
    return (h / 16) * 256 + (h % 8) * 32 + (l / 128) * 16 + (l / 2) % 16;
`else
    return (h / 32) * 32 + (h % 8) * 4 + (l / 8) % 4;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    wr_t w;
    cyc++;
    @(posedge clk);
    #1;
    if (bus.mem_we) begin
      wr_cnt++;
      chk("we_b2b", 32'(prev_we), 32'd0);
    end
    prev_we = bus.mem_we;
    done_cnt += int'(bus.frame_done);
    err_cnt += int'(bus.frame_err);
    if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      w = exp_q.pop_front();
      chk("we", 32'(bus.mem_we), 32'd1);
      chk("addr", 32'(bus.mem_addr), 32'(w.addr));
      chk("data", 32'(bus.mem_data), 32'(w.data));
    end else if (bus.mem_we) chk("we_unexp", 32'(bus.mem_we), 32'd0);
  endtask

  task automatic put_byte(input logic [7:0] b);
    wr_t w;
    bus.CAM_HREF = 1'b1;
    bus.CAM_px_data = b;
    if (byte_n % 2 == 0) hi_b = b;
    else if (cap && line_n < V_LINES && byte_n / 2 < H_PIXELS) begin
      w.addr = line_n * H_PIXELS + byte_n / 2;
      w.data = pack(hi_b, b);
      w.cyc = cyc + 1;
      exp_q.push_back(w);
      exp_wr++;
    end
    byte_n++;
    tick();
  endtask

  task automatic send_line(input int n, input bit vs);
    repeat (n) put_byte(8'($urandom));
    bus.CAM_HREF = 1'b0;
    if (vs) bus.CAM_VSYNC = 1'b1;
    line_n++;
    byte_n = 0;
    repeat (4) tick();
  endtask

  task automatic start_frame(input bit en);
    bus.CAM_VSYNC = 1'b1;
    bus.CAM_HREF = 1'b0;
    repeat (3) tick();
    bus.capture_en = en;
    bus.CAM_VSYNC = 1'b0;
    cap = en;
    line_n = 0;
    byte_n = 0;
    exp_wr = 0;
    wr_cnt = 0;
    done_cnt = 0;
    err_cnt = 0;
    tick();
    bus.capture_en = 1'($urandom);
    repeat (2) tick();
  endtask

  task automatic end_frame(input string tag);
    bus.CAM_VSYNC = 1'b1;
    bus.CAM_HREF = 1'b0;
    repeat (4) tick();
    chk({tag, "_done"}, 32'(done_cnt), 32'(cap && line_n == V_LINES));
    chk({tag, "_err"}, 32'(err_cnt), 32'(cap && line_n != V_LINES));
    chk({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(exp_wr));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_data"}, 32'(bus.mem_data), 32'd0);
    chk({tag, "_done"}, 32'(bus.frame_done), 32'd0);
    chk({tag, "_err"}, 32'(bus.frame_err), 32'd0);
  endtask

  initial begin
    bus.capture_en = 1'b0;
    bus.CAM_VSYNC = 1'b1;
    bus.CAM_HREF = 1'b0;
    bus.CAM_px_data = '0;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;

    // full frame of constant E0, last HREF fall coincides with VSYNC rise
    start_frame(1'b1);
    for (int l = 0; l < V_LINES; l++) begin
      repeat (2 * H_PIXELS) put_byte(8'hE0);
      bus.CAM_HREF = 1'b0;
      if (l == V_LINES - 1) bus.CAM_VSYNC = 1'b1;
      line_n++;
      byte_n = 0;
      repeat (4) tick();
    end
    end_frame("full");
    chk("full_writes", 32'(wr_cnt), 32'd19200);

    // truncated frame: short odd line 5, overlong line 7, VSYNC after 60 lines
    start_frame(1'b1);
    for (int l = 0; l < 60; l++) send_line(l == 5 ? 201 : l == 7 ? 340 : 2 * H_PIXELS, 1'b0);
    end_frame("trunc");
    chk("trunc_writes", 32'(wr_cnt), 32'd9540);

    // disarmed frame
    start_frame(1'b0);
    for (int l = 0; l < 5; l++) send_line(2 * H_PIXELS, 1'b0);
    end_frame("disarm");

    // reset in the middle of line 30
    start_frame(1'b1);
    for (int l = 0; l < 30; l++) send_line(2 * H_PIXELS, 1'b0);
    repeat (50) put_byte(8'($urandom));
    rst = 1'b1;
    cap = 1'b0;
    tick();
    chk_zero("midrst");
    rst = 1'b0;
    repeat (270) put_byte(8'($urandom));
    bus.CAM_HREF = 1'b0;
    line_n++;
    byte_n = 0;
    repeat (4) tick();
    for (int l = 0; l < 3; l++) send_line(2 * H_PIXELS, 1'b0);
    end_frame("rstfr");

    // known RGB565 pair in a short frame
    start_frame(1'b1);
    put_byte(8'hF8);
    put_byte(8'h1F);
    chk("px_f81f", 32'(bus.mem_data), PX_EXP);
    send_line(2 * H_PIXELS - 2, 1'b0);
    send_line(2 * H_PIXELS, 1'b0);
    end_frame("pair");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
